// File: rtl/instr_fetch_decode.sv
// Fetch/decode sequencer for the 4-bit datapath. It fetches 8-bit words over
// a req/ack handshake, decodes them, and issues gated one-cycle control words
// over a valid/ready handshake. It also handles NOP, JMP, HALT and illegal
// opcodes internally.
module instr_fetch_decode #(
   parameter int DATA_W = 4,
   parameter int PC_W   = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              run,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [7:0]        imem_data,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [1:0]        Tx,
   output logic [1:0]        Ty,
   output logic [1:0]        Tz,
   output logic              Talu,
   output logic [DATA_W-1:0] valueMemory,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic              illegal
);

   localparam logic [1:0] C_HOLD  = 2'b00;
   localparam logic [1:0] C_LOAD  = 2'b01;
   localparam logic [1:0] C_CLEAR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALTED
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [7:0]          r_instr;
   logic [PC_W-1:0]     r_pc;
   logic [1:0]          r_tx, r_ty, r_tz;
   logic                r_talu;
   logic [DATA_W-1:0]   r_val;
   logic                r_illegal;

   logic [3:0]          w_opcode;
   logic [3:0]          w_imm;
   logic [1:0]          w_dec_tx, w_dec_ty, w_dec_tz;
   logic                w_dec_talu;
   logic                w_fire;

   assign w_opcode = r_instr[7:4];
   assign w_imm    = r_instr[3:0];
   assign w_fire   = (r_state == S_ISSUE) && issue_ready;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state logic; NOP, JMP and illegal words go straight back to FETCH
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (run) w_state_next = S_FETCH;
         S_FETCH:  if (imem_ack) w_state_next = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5: w_state_next = S_ISSUE;
               4'h7:                         w_state_next = S_HALTED;
               default:                      w_state_next = S_FETCH;
            endcase
         end
         S_ISSUE:  if (issue_ready) w_state_next = S_FETCH;
         S_HALTED: w_state_next = S_HALTED;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Opcode decode into a control word; fields not named by the opcode stay HOLD
   always_comb begin
      w_dec_tx   = C_HOLD;
      w_dec_ty   = C_HOLD;
      w_dec_tz   = C_HOLD;
      w_dec_talu = 1'b0;
      case (w_opcode)
         4'h1: w_dec_tx = C_LOAD;
         4'h2: w_dec_ty = C_LOAD;
         4'h3: begin
            w_dec_ty   = C_LOAD;
            w_dec_talu = 1'b1;
         end
         4'h4: w_dec_tz = C_LOAD;
         4'h5: begin
            w_dec_tx = C_CLEAR;
            w_dec_ty = C_CLEAR;
            w_dec_tz = C_CLEAR;
         end
         default: ;
      endcase
   end

   // Datapath: instruction latch, control word, immediate, pc and sticky illegal
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_instr   <= 8'h00;
         r_pc      <= '0;
         r_tx      <= C_HOLD;
         r_ty      <= C_HOLD;
         r_tz      <= C_HOLD;
         r_talu    <= 1'b0;
         r_val     <= '0;
         r_illegal <= 1'b0;
      end else begin
         if (r_state == S_FETCH && imem_ack) r_instr <= imem_data;
         if (r_state == S_DECODE) begin
            r_tx   <= w_dec_tx;
            r_ty   <= w_dec_ty;
            r_tz   <= w_dec_tz;
            r_talu <= w_dec_talu;
            if (w_opcode == 4'h1) r_val <= DATA_W'(w_imm);
            if (w_opcode[3])      r_illegal <= 1'b1;
            if (w_opcode == 4'h6)
               r_pc <= PC_W'(w_imm);
            else if (w_opcode == 4'h0 || w_opcode[3])
               r_pc <= r_pc + 1'b1;
         end
         if (w_fire) r_pc <= r_pc + 1'b1;
      end
   end

   // Outputs; control codes are visible only in the accepting cycle
   always_comb begin
      imem_req    = (r_state == S_FETCH);
      imem_addr   = r_pc;
      issue_valid = (r_state == S_ISSUE);
      Tx          = w_fire ? r_tx   : C_HOLD;
      Ty          = w_fire ? r_ty   : C_HOLD;
      Tz          = w_fire ? r_tz   : C_HOLD;
      Talu        = w_fire ? r_talu : 1'b0;
      valueMemory = r_val;
      pc          = r_pc;
      halted      = (r_state == S_HALTED);
      illegal     = r_illegal;
   end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: directed programs push expected
// control words; a monitor pops and compares on every accepted issue.
module tb_instr_fetch_decode;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       run = 1'b0;
   logic       imem_req;
   logic [2:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'h00;
   logic       issue_valid;
   logic       issue_ready = 1'b0;
   logic [1:0] Tx, Ty, Tz;
   logic       Talu;
   logic [3:0] valueMemory;
   logic [2:0] pc;
   logic       halted;
   logic       illegal;

   typedef struct packed {
      logic [1:0] tx, ty, tz;
      logic       talu;
      logic [3:0] val;
      logic [2:0] pc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mem [8];
   int         ack_delay = 0;
   int         checks = 0;
   int         errors = 0;
   int         n_issue = 0;

   instr_fetch_decode #(.DATA_W(4), .PC_W(3)) dut (
      .clock(clock), .reset_n(reset_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .Tx(Tx), .Ty(Ty), .Tz(Tz), .Talu(Talu), .valueMemory(valueMemory),
      .pc(pc), .halted(halted), .illegal(illegal)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      run = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_halt(input int budget);
      for (int i = 0; i < budget && !halted; i++) tick();
      chk("halt_reached", int'(halted), 1);
   endtask

   // Program memory with a programmable number of wait cycles before ack
   initial begin
      int cnt = 0;
      forever begin
         @(negedge clock);
         if (imem_req && reset_n) begin
            if (cnt >= ack_delay) begin
               imem_ack  = 1'b1;
               imem_data = mem[imem_addr];
               cnt = 0;
            end else begin
               imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor: pops on accepted issues, checks gating and valid stability
   initial begin
      logic prev_wait = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            prev_wait = 1'b0;
         end else begin
            if (prev_wait) chk("valid_held", int'(issue_valid), 1);
            if (issue_valid && issue_ready) begin
               n_issue++;
               if (sb.size() == 0) begin
                  chk("unexpected_issue", int'({Tx, Ty, Tz, Talu, valueMemory, pc}), 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("issue pc=%0d Tx=%b Ty=%b Tz=%b Talu=%b val=%0h (exp Tx=%b Ty=%b Tz=%b Talu=%b val=%0h pc=%0d)",
                           pc, Tx, Ty, Tz, Talu, valueMemory, e.tx, e.ty, e.tz, e.talu, e.val, e.pc);
                  chk("issue_word", int'({Tx, Ty, Tz, Talu, valueMemory, pc}), int'(e));
               end
            end else begin
               chk("gated_hold", int'({Tx, Ty, Tz, Talu}), 0);
            end
            prev_wait = issue_valid && !issue_ready;
         end
      end
   end

   initial begin
      int trace[$];
      int last;
      int exp_trace[5] = '{0, 6, 7, 0, 6};

      // Reset state
      #1;
      chk("rst_req", int'(imem_req), 0);
      chk("rst_pc", int'(pc), 0);
      chk("rst_outs", int'({issue_valid, Tx, Ty, Tz, Talu, valueMemory, halted, illegal}), 0);
      do_reset();

      // 1: reset mid-fetch
      ack_delay = 20;
      run = 1'b1;
      for (int i = 0; i < 20 && !imem_req; i++) tick();
      chk("t1_req_up", int'(imem_req), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t1_req_rst", int'(imem_req), 0);
      chk("t1_pc_rst", int'(pc), 0);
      chk("t1_outs_rst", int'({issue_valid, Tx, Ty, Tz, Talu, valueMemory, halted, illegal}), 0);
      do_reset();

      // 2: LDX 5, ADD, MOVZ, HALT with zero-wait ack and ready=1
      mem = '{8'h15, 8'h20, 8'h40, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00};
      ack_delay = 0;
      issue_ready = 1'b1;
      n_issue = 0;
      sb.push_back('{tx:2'b01, ty:2'b00, tz:2'b00, talu:1'b0, val:4'h5, pc:3'd0});
      sb.push_back('{tx:2'b00, ty:2'b01, tz:2'b00, talu:1'b0, val:4'h5, pc:3'd1});
      sb.push_back('{tx:2'b00, ty:2'b00, tz:2'b01, talu:1'b0, val:4'h5, pc:3'd2});
      run = 1'b1;
      tick();
      run = 1'b0;
      wait_halt(200);
      tick();
      chk("t2_pc", int'(pc), 3);
      chk("t2_req", int'(imem_req), 0);
      chk("t2_valid", int'(issue_valid), 0);
      chk("t2_issues", n_issue, 3);
      chk("t2_sb_empty", sb.size(), 0);
      do_reset();

      // 3: ready held low for 4 cycles on ADD, then SUB, HALT
      mem = '{8'h20, 8'h30, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      issue_ready = 1'b0;
      sb.push_back('{tx:2'b00, ty:2'b01, tz:2'b00, talu:1'b0, val:4'h0, pc:3'd0});
      sb.push_back('{tx:2'b00, ty:2'b01, tz:2'b00, talu:1'b1, val:4'h0, pc:3'd1});
      run = 1'b1;
      for (int i = 0; i < 20 && !issue_valid; i++) tick();
      for (int i = 0; i < 4; i++) begin
         chk("t3_valid_wait", int'(issue_valid), 1);
         chk("t3_ty_hold", int'(Ty), 0);
         chk("t3_pc_wait", int'(pc), 0);
         tick();
      end
      issue_ready = 1'b1;
      tick();
      chk("t3_pc_adv", int'(pc), 1);
      chk("t3_valid_drop", int'(issue_valid), 0);
      wait_halt(200);
      chk("t3_pc_halt", int'(pc), 2);
      chk("t3_sb_empty", sb.size(), 0);
      do_reset();

      // 4: ack delayed by 3 cycles
      mem = '{8'h1A, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      ack_delay = 3;
      sb.push_back('{tx:2'b01, ty:2'b00, tz:2'b00, talu:1'b0, val:4'hA, pc:3'd0});
      run = 1'b1;
      for (int i = 0; i < 20 && !imem_req; i++) tick();
      for (int i = 0; i < 3; i++) begin
         chk("t4_req_held", int'(imem_req), 1);
         chk("t4_addr_held", int'(imem_addr), 0);
         chk("t4_no_issue", int'(issue_valid), 0);
         tick();
      end
      wait_halt(200);
      chk("t4_pc_halt", int'(pc), 1);
      chk("t4_sb_empty", sb.size(), 0);
      do_reset();

      // 5: illegal at 6, NOP at 7 wraps to 0, JMP 6; word at 6 becomes HALT
      mem = '{8'h66, 8'h70, 8'h70, 8'h70, 8'h70, 8'h70, 8'hA0, 8'h00};
      ack_delay = 0;
      n_issue = 0;
      run = 1'b1;
      last = int'(pc);
      trace.push_back(last);
      for (int i = 0; i < 300 && !halted; i++) begin
         tick();
         if (int'(pc) != last) begin
            last = int'(pc);
            trace.push_back(last);
            if (last == 7) mem[6] = 8'h70;
         end
      end
      chk("t5_halted", int'(halted), 1);
      chk("t5_trace_len", trace.size(), 5);
      for (int i = 0; i < 5 && i < trace.size(); i++) chk("t5_trace", trace[i], exp_trace[i]);
      chk("t5_illegal", int'(illegal), 1);
      chk("t5_no_issue", n_issue, 0);
      tick();
      tick();
      chk("t5_illegal_sticky", int'(illegal), 1);
      chk("t5_pc_final", int'(pc), 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
